// File: rtl/calc_sequencer_if.sv
// Request/response link between calc_sequencer (master) and the shared
// multi-cycle arithmetic unit (slave).
interface calc_sequencer_if;
  logic       op_start;
  logic [1:0] op_sel;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_done;
  logic [7:0] op_res;

  modport master (
    output op_start, op_sel, op_a, op_b,
    input  op_done, op_res
  );

  modport slave (
    input  op_start, op_sel, op_a, op_b,
    output op_done, op_res
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: debounces the four op buttons, latches operands from sw,
// runs one start/done transaction on the arithmetic unit and holds the
// result for the display path.
// Optional feature macro: CALC_SEQ_TIMEOUT_EN bounds the wait for op_done
// to TMO_CYCLES cycles and reports a timeout as err=1.
module calc_sequencer #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int TMO_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              btn,
  input  logic [7:0]              sw,
  calc_sequencer_if.master        bus,
  output logic [7:0]              res,
  output logic                    sign,
  output logic                    err,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 2");
  end
  if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
    $error("TMO_CYCLES must fit the 8-bit wait counter (1..255)");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_WAIT,
    S_SHOW
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [3:0]       r_btn_s1;
  logic [3:0]       r_btn_s2;
  logic [3:0]       r_deb_pat;
  logic [CNT_W-1:0] r_deb_cnt;
  logic             r_fired;

  logic [1:0]       r_op_sel;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic [7:0]       r_res;
  logic             r_sign;
  logic             r_err;
  logic             r_busy;

  logic [3:0]       w_sync;
  logic             w_onehot;
  logic             w_press;
  logic [1:0]       w_idx;
  logic             w_div0;

`ifdef CALC_SEQ_TIMEOUT_EN
  logic [7:0]       r_tmo;
  logic             w_tmo;
  assign w_tmo = (r_tmo == 8'(TMO_CYCLES - 1));
`endif

  assign w_sync   = r_btn_s2;
  assign w_onehot = (w_sync != 4'd0) && ((w_sync & (w_sync - 4'd1)) == 4'd0);
  // One event per press: the pattern must have been seen for DEB_CYCLES
  // consecutive cycles, and r_fired blocks repeats until all buttons release.
  assign w_press  = w_onehot && (w_sync == r_deb_pat) &&
                    (r_deb_cnt == CNT_W'(DEB_CYCLES - 1)) && !r_fired;
  assign w_div0   = (r_op_sel == 2'd3) && (sw[3:0] == 4'd0);

  assign bus.op_start = (r_state == S_START);
  assign bus.op_sel   = r_op_sel;
  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign res          = r_res;
  assign sign         = r_sign;
  assign err          = r_err;
  assign busy         = r_busy;

  // Encode the debounced one-hot button pattern into the operation code.
  always_comb begin
    w_idx = 2'd0;
    case (w_sync)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // Synchronise raw buttons and count how long a single button stays pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1  <= 4'd0;
      r_btn_s2  <= 4'd0;
      r_deb_pat <= 4'd0;
      r_deb_cnt <= '0;
      r_fired   <= 1'b0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      if (!w_onehot) begin
        r_deb_pat <= 4'd0;
        r_deb_cnt <= '0;
      end else if (w_sync != r_deb_pat) begin
        r_deb_pat <= w_sync;
        r_deb_cnt <= CNT_W'(1);
      end else if (r_deb_cnt != CNT_W'(DEB_CYCLES - 1)) begin
        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
      end
      if (w_sync == 4'd0) begin
        r_fired <= 1'b0;
      end else if (w_press) begin
        r_fired <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; press events outside IDLE and op_done outside WAIT are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_press) w_next = S_LATCH;
      S_LATCH: w_next = w_div0 ? S_SHOW : S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.op_done) begin
          w_next = S_SHOW;
        end
`ifdef CALC_SEQ_TIMEOUT_EN
        else if (w_tmo) begin
          w_next = S_SHOW;
        end
`endif
      end
      S_SHOW:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/result registers; busy rises with the press and falls with the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_sel <= 2'd0;
      r_op_a   <= 4'd0;
      r_op_b   <= 4'd0;
      r_res    <= 8'd0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
      r_tmo    <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_op_sel <= w_idx;
            r_busy   <= 1'b1;
          end
        end
        S_LATCH: begin
          r_op_a <= sw[7:4];
          r_op_b <= sw[3:0];
          if (w_div0) begin
            r_res  <= 8'd0;
            r_sign <= 1'b0;
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_START: begin
`ifdef CALC_SEQ_TIMEOUT_EN
          r_tmo <= 8'd0;
`endif
        end
        S_WAIT: begin
          if (bus.op_done) begin
            r_res  <= bus.op_res;
            r_sign <= (r_op_sel == 2'd1) && (r_op_a < r_op_b);
            r_err  <= 1'b0;
            r_busy <= 1'b0;
          end
`ifdef CALC_SEQ_TIMEOUT_EN
          else if (w_tmo) begin
            r_res  <= 8'd0;
            r_sign <= 1'b0;
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: randomized button/operand transactions against a
// transaction-level model, a responder standing in for the arithmetic unit,
// and directed reset, debounce, divide-by-zero and wait-bound scenarios.
module tb_calc_sequencer;
  localparam int DEB = 4;
  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [7:0] sw;
  logic [7:0] res;
  logic       sign;
  logic       err;
  logic       busy;

  calc_sequencer_if ifc();

  calc_sequencer #(.DEB_CYCLES(DEB), .TMO_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .bus  (ifc),
    .res  (res),
    .sign (sign),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the transaction currently expected / last shown.
  int m_sel, m_a, m_b;
  bit m_expect_start = 0, m_in_flight = 0, m_due = 0, m_hold_valid = 1;
  int m_exp_res;
  bit m_exp_sign;
  int m_hold_res = 0;
  bit m_hold_sign = 0, m_hold_err = 0;
  int m_done_cnt = 0, n_starts = 0, c_sel = 0;

  // Arithmetic unit stand-in controls.
  bit unit_on = 1, force_done = 0;
  int unit_delay = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_calc(input int sel, input int a, input int b);
    case (sel)
      0: return a + b;
      1: return (a >= b) ? a - b : b - a;
      2: return a * b;
      default: return (b != 0) ? a / b : 0;
    endcase
  endfunction

  // Arithmetic unit: answers each op_start after unit_delay cycles with a one-cycle op_done.
  initial begin
    int r;
    ifc.op_done = 1'b0;
    ifc.op_res  = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst && ((ifc.op_start && unit_on) || force_done)) begin
        if (force_done) begin
          force_done = 0;
          r = 8'hA5;
        end else begin
          r = ref_calc(int'(ifc.op_sel), int'(ifc.op_a), int'(ifc.op_b));
          repeat (unit_delay - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        ifc.op_done = 1'b1;
        ifc.op_res  = 8'(r);
        @(posedge clk); #1;
        ifc.op_done = 1'b0;
        ifc.op_res  = 8'($urandom);
      end
    end
  end

  // Per-cycle compare against the transaction model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_due) begin
          chk("res_value", int'(res), m_exp_res);
          chk("res_sign", int'(sign), int'(m_exp_sign));
          chk("res_err", int'(err), 0);
          chk("busy_fall", int'(busy), 0);
          m_hold_res  = m_exp_res;
          m_hold_sign = m_exp_sign;
          m_hold_err  = 1'b0;
          m_due = 0;
          m_done_cnt++;
        end else if (m_hold_valid) begin
          chk("res_hold", int'(res), m_hold_res);
          chk("sign_hold", int'(sign), int'(m_hold_sign));
          chk("err_hold", int'(err), int'(m_hold_err));
        end
        if (ifc.op_start) begin
          n_starts++;
          chk("start_expected", int'(ifc.op_start), int'(m_expect_start));
          chk("start_sel", int'(ifc.op_sel), m_sel);
          chk("start_a", int'(ifc.op_a), m_a);
          chk("start_b", int'(ifc.op_b), m_b);
          c_sel = int'(ifc.op_sel);
          m_expect_start = 0;
          m_in_flight = 1;
        end
        if (m_in_flight) begin
          chk("stable_sel", int'(ifc.op_sel), m_sel);
          chk("stable_a", int'(ifc.op_a), m_a);
          chk("stable_b", int'(ifc.op_b), m_b);
          chk("busy_in_flight", int'(busy), 1);
          if (ifc.op_done) begin
            m_due = 1;
            m_exp_res  = ref_calc(m_sel, m_a, m_b) & 8'hFF;
            m_exp_sign = (m_sel == 1) && (m_a < m_b);
            m_in_flight = 0;
          end
        end
      end
    end
  end

  task automatic do_op(input int idx, input logic [7:0] swv, input int hold, input int dly);
    int d0, s0, k;
    bit div0;
    div0 = (idx == 3) && (swv[3:0] == 4'd0);
    sw = swv;
    m_sel = idx;
    m_a = int'(swv[7:4]);
    m_b = int'(swv[3:0]);
    unit_delay = dly;
    d0 = m_done_cnt;
    s0 = n_starts;
    if (div0) m_hold_valid = 0;
    else      m_expect_start = 1;
    btn = 4'(1 << idx);
    repeat (hold) @(posedge clk);
    #1 btn = 4'd0;
    repeat (2) @(posedge clk);
    #1 sw = 8'($urandom);
    if (div0) begin
      repeat (6) @(posedge clk);
      #2;
      chk("div0_no_start", n_starts - s0, 0);
      chk("div0_err", int'(err), 1);
      chk("div0_res", int'(res), 0);
      chk("div0_sign", int'(sign), 0);
      chk("div0_busy", int'(busy), 0);
      m_hold_res = 0; m_hold_sign = 0; m_hold_err = 1;
      m_hold_valid = 1;
    end else begin
      k = 0;
      while (m_done_cnt == d0 && k < 80) begin
        @(posedge clk); #2;
        k++;
      end
      chk("op_completed", m_done_cnt - d0, 1);
      chk("one_start", n_starts - s0, 1);
      chk("busy_idle", int'(busy), 0);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic press_until_start(input int idx, input logic [7:0] swv);
    int k;
    sw = swv;
    m_sel = idx; m_a = int'(swv[7:4]); m_b = int'(swv[3:0]);
    m_expect_start = 1;
    btn = 4'(1 << idx);
    repeat (6) @(posedge clk);
    #1 btn = 4'd0;
    k = 0;
    while (!ifc.op_start && k < 30) begin
      @(posedge clk); #2;
      k++;
    end
    chk("start_seen", int'(ifc.op_start), 1);
  endtask

  task automatic clear_model();
    m_in_flight = 0; m_expect_start = 0; m_due = 0;
    m_hold_res = 0; m_hold_sign = 0; m_hold_err = 0; m_hold_valid = 1;
  endtask

  // Watchdog bounding the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int s0, idx, dly, hold;
    logic [7:0] v;
    rst = 1'b1; btn = 4'd0; sw = 8'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_res", int'(res), 0);
    chk("rst_sign", int'(sign), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(ifc.op_start), 0);
    chk("rst_sel", int'(ifc.op_sel), 0);
    chk("rst_a", int'(ifc.op_a), 0);
    chk("rst_b", int'(ifc.op_b), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    do_op(0, 8'h35, 6, 3);
    chk("lit_add_sel", c_sel, 0);
    chk("lit_add_res", int'(res), 8);
    chk("lit_add_sign", int'(sign), 0);
    do_op(1, 8'h35, 6, 2);
    chk("lit_sub_res", int'(res), 2);
    chk("lit_sub_sign", int'(sign), 1);
    do_op(1, 8'h53, 6, 2);
    chk("lit_sub2_res", int'(res), 2);
    chk("lit_sub2_sign", int'(sign), 0);
    do_op(3, 8'h70, 6, 1);
    do_op(3, 8'h72, 6, 4);
    chk("lit_div_res", int'(res), 3);
    chk("lit_div_err", int'(err), 0);
    do_op(2, 8'hFF, 7, 5);
    chk("lit_mul_res", int'(res), 225);

    // Short press and multi-button press must not start anything.
    s0 = n_starts;
    btn = 4'b0001;
    repeat (3) @(posedge clk);
    #1 btn = 4'd0;
    repeat (12) @(posedge clk);
    #1 btn = 4'b0011;
    repeat (10) @(posedge clk);
    #1 btn = 4'd0;
    repeat (12) @(posedge clk);
    #2;
    chk("no_start_bad_press", n_starts - s0, 0);
    chk("no_start_busy", int'(busy), 0);

    // A long press fires exactly once (checked inside do_op).
    do_op(0, 8'h9C, 30, 2);
    chk("lit_held_res", int'(res), 21);

    for (int i = 0; i < 24; i++) begin
      idx  = int'($urandom_range(0, 3));
      v    = 8'($urandom);
      dly  = int'($urandom_range(1, 6));
      hold = int'($urandom_range(6, 12));
      do_op(idx, v, hold, dly);
    end

    // Reset in the middle of a transaction; a later op_done is ignored.
    unit_on = 0;
    s0 = n_starts;
    press_until_start(1, 8'h12);
    repeat (4) @(posedge clk);
    #2 chk("pre_rst_busy", int'(busy), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_res", int'(res), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_sign", int'(sign), 0);
    chk("mid_rst_sel", int'(ifc.op_sel), 0);
    chk("mid_rst_a", int'(ifc.op_a), 0);
    chk("mid_rst_b", int'(ifc.op_b), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    force_done = 1;
    repeat (6) @(posedge clk);
    #2;
    chk("late_done_res", int'(res), 0);
    chk("late_done_busy", int'(busy), 0);
    chk("late_done_err", int'(err), 0);
    chk("late_done_starts", n_starts - s0, 1);

`ifdef CALC_SEQ_TIMEOUT_EN
    press_until_start(2, 8'h45);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
    end
    chk("tmo_not_yet_err", int'(err), 0);
    chk("tmo_not_yet_busy", int'(busy), 1);
    m_in_flight = 0;
    m_hold_valid = 0;
    @(posedge clk); #2;
    chk("tmo_err", int'(err), 1);
    chk("tmo_res", int'(res), 0);
    chk("tmo_sign", int'(sign), 0);
    chk("tmo_busy", int'(busy), 0);
    m_hold_res = 0; m_hold_sign = 0; m_hold_err = 1; m_hold_valid = 1;
`else
    press_until_start(2, 8'h45);
    repeat (40) @(posedge clk);
    #2;
    chk("no_tmo_busy", int'(busy), 1);
    chk("no_tmo_err", int'(err), 0);
    #1 rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`endif
    unit_on = 1;
    repeat (3) @(posedge clk);
    #1;
    do_op(0, 8'h12, 6, 1);
    chk("lit_final_res", int'(res), 3);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
